// File: rtl/codificador_pt2262_param_if.sv
// Control-side bundle for the PT2262-style encoder: request/hold, frame payload and status.
interface codificador_pt2262_param_if #(
    parameter int N_ADDR = 8,
    parameter int N_DATA = 4
);
    logic                  start;
    logic                  hold;
    logic [2*N_ADDR-1:0]   A;
    logic [N_DATA-1:0]     D;
    logic                  busy;
    logic                  sync;
    logic                  cod_o;
    logic                  done;
    logic                  err;

    modport master (
        output start, hold, A, D,
        input  busy, sync, cod_o, done, err
    );

    modport slave (
        input  start, hold, A, D,
        output busy, sync, cod_o, done, err
    );
endinterface

// File: rtl/codificador_pt2262_param.sv
// Parametrised PT2262-style OOK encoder: N_ADDR trits + N_DATA bits + sync, repeated REPEAT times (or while hold).
// Latency: cod_o rises the cycle after start is accepted; frame = ((N_ADDR+N_DATA)*32+128)*CLK_DIV cycles.
// Backpressure: none; start is only sampled in IDLE, ignored while busy.
module codificador_pt2262_param #(
    parameter int N_ADDR  = 8,
    parameter int N_DATA  = 4,
    parameter int CLK_DIV = 250,
    parameter int REPEAT  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    codificador_pt2262_param_if.slave   bus
);
    localparam int N_SYM = N_ADDR + N_DATA;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int IDX_W = $clog2(N_SYM);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SYM - 1);
    localparam logic [7:0]       REPEAT_Q = 8'(REPEAT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BIT,
        S_SYNC
    } state_t;

    state_t              state_q;
    logic [DIV_W-1:0]    div_q;
    logic [6:0]          phase_q;
    logic [IDX_W-1:0]    idx_q;
    logic [7:0]          frame_q;
    logic [2*N_ADDR-1:0] a_q;
    logic [N_DATA-1:0]   d_q;
    logic                cod_q;
    logic                sync_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

    logic                tick;
    logic [7:0]          frame_next;

    function automatic logic has_reserved(input logic [2*N_ADDR-1:0] a);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N_ADDR; i++) begin
            if (a[2*i +: 2] == 2'b10) r = 1'b1;
        end
        return r;
    endfunction

    // Data bits are sent as the '1'/'0' trit codes, MSB first after the address.
    function automatic logic [1:0] symbol(input logic [IDX_W-1:0]    idx,
                                          input logic [2*N_ADDR-1:0] a,
                                          input logic [N_DATA-1:0]   d);
        logic [1:0] s;
        s = 2'b00;
        for (int i = 0; i < N_ADDR; i++) begin
            if (int'(idx) == i) s = a[2*i +: 2];
        end
        for (int j = 0; j < N_DATA; j++) begin
            if (int'(idx) == N_ADDR + j) s = {2{d[N_DATA-1-j]}};
        end
        return s;
    endfunction

    // Each half-symbol is a short (4) or long (12) high pulse out of 16 phases.
    function automatic logic wave(input logic [1:0] s, input logic [4:0] p);
        logic long_pulse;
        if (p[4] == 1'b0) long_pulse = (s == 2'b11);
        else              long_pulse = (s != 2'b00);
        return (p[3:0] < 4'd4) || (long_pulse && (p[3:0] < 4'd12));
    endfunction

    assign tick       = (state_q != S_IDLE) && (div_q == DIV_LAST);
    assign frame_next = (frame_q == 8'hFF) ? 8'hFF : frame_q + 8'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            phase_q <= '0;
            idx_q   <= '0;
            frame_q <= '0;
            a_q     <= '0;
            d_q     <= '0;
            cod_q   <= 1'b0;
            sync_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    div_q <= '0;
                    if (bus.start) begin
                        a_q <= bus.A;
                        d_q <= bus.D;
                        if (has_reserved(bus.A)) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q <= S_BIT;
                            idx_q   <= '0;
                            phase_q <= '0;
                            frame_q <= '0;
                            busy_q  <= 1'b1;
                            cod_q   <= 1'b1;
                        end
                    end
                end

                S_BIT: begin
                    div_q <= tick ? '0 : div_q + DIV_W'(1);
                    if (tick) begin
                        if (phase_q == 7'd31) begin
                            phase_q <= '0;
                            cod_q   <= 1'b1;
                            if (idx_q == IDX_LAST) begin
                                state_q <= S_SYNC;
                                sync_q  <= 1'b1;
                            end else begin
                                idx_q <= idx_q + IDX_W'(1);
                            end
                        end else begin
                            phase_q <= phase_q + 7'd1;
                            cod_q   <= wave(symbol(idx_q, a_q, d_q), phase_q[4:0] + 5'd1);
                        end
                    end
                end

                S_SYNC: begin
                    div_q <= tick ? '0 : div_q + DIV_W'(1);
                    if (tick) begin
                        if (phase_q == 7'd127) begin
                            phase_q <= '0;
                            sync_q  <= 1'b0;
                            idx_q   <= '0;
                            frame_q <= frame_next;
                            if (bus.hold || (frame_next < REPEAT_Q)) begin
                                a_q <= bus.A;
                                d_q <= bus.D;
                                if (has_reserved(bus.A)) begin
                                    err_q   <= 1'b1;
                                    state_q <= S_IDLE;
                                    busy_q  <= 1'b0;
                                    cod_q   <= 1'b0;
                                end else begin
                                    state_q <= S_BIT;
                                    cod_q   <= 1'b1;
                                end
                            end else begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                cod_q   <= 1'b0;
                            end
                        end else begin
                            phase_q <= phase_q + 7'd1;
                            cod_q   <= (phase_q + 7'd1) < 7'd4;
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    sync_q  <= 1'b0;
                    cod_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.sync  = sync_q;
    assign bus.cod_o = cod_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_codificador_pt2262_param.sv
// Directed bench: small 2+2 encoder (REPEAT=1) and default 8+4 encoder (REPEAT=2), both CLK_DIV=2.
module tb_codificador_pt2262_param;
    localparam int FR1 = (4 * 32 + 128) * 2;
    localparam int FR2 = (12 * 32 + 128) * 2;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    codificador_pt2262_param_if #(.N_ADDR(2), .N_DATA(2)) if1 ();
    codificador_pt2262_param_if #(.N_ADDR(8), .N_DATA(4)) if2 ();

    codificador_pt2262_param #(.N_ADDR(2), .N_DATA(2), .CLK_DIV(2), .REPEAT(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    codificador_pt2262_param #(.N_ADDR(8), .N_DATA(4), .CLK_DIV(2), .REPEAT(2)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Symbol list: address trits first, then data bits MSB first as 11/00.
    function automatic logic [31:0] mk_syms(input logic [31:0] a, input int na,
                                            input logic [7:0] d, input int nd);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < 2 * na; i++) s[i] = a[i];
        for (int j = 0; j < nd; j++) s[2*(na+j) +: 2] = {2{d[nd-1-j]}};
        return s;
    endfunction

    function automatic logic exp_cod(input int kk, input int nsym, input int cdiv,
                                     input logic [31:0] syms);
        int          ph;
        logic [1:0]  s;
        logic [31:0] m;
        ph = kk / cdiv;
        if (ph >= nsym * 32) return (ph - nsym * 32) < 4;
        s = syms[2*(ph/32) +: 2];
        case (s)
            2'b00:   m = 32'h000F_000F;
            2'b11:   m = 32'h0FFF_0FFF;
            default: m = 32'h0FFF_000F;
        endcase
        return m[ph % 32];
    endfunction

    function automatic logic exp_sync(input int kk, input int nsym, input int cdiv);
        return (kk / cdiv) >= nsym * 32;
    endfunction

    task automatic run1(input string tag, input logic [3:0] a0, input logic [1:0] d0,
                        input logic [3:0] a_new, input int chg_k, input int drop_k,
                        input int pulse_k, input int nfr);
        int          mism;
        int          nsync;
        int          f;
        int          kk;
        logic [31:0] syms0;
        logic [31:0] syms1;
        logic [31:0] sy;
        mism  = 0;
        nsync = 0;
        syms0 = mk_syms({28'd0, a0}, 2, {6'd0, d0}, 2);
        syms1 = mk_syms({28'd0, a_new}, 2, {6'd0, d0}, 2);
        @(negedge clk);
        if1.A     = a0;
        if1.D     = d0;
        if1.start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < FR1 * nfr + 2; k++) begin
            @(negedge clk);
            if (k == 0) if1.start = 1'b0;
            if (k < FR1 * nfr) begin
                f  = k / FR1;
                kk = k % FR1;
                sy = (f > 0 && chg_k >= 0 && chg_k < FR1 * f) ? syms1 : syms0;
                if (if1.cod_o !== exp_cod(kk, 4, 2, sy)) mism++;
                if (if1.sync !== exp_sync(kk, 4, 2)) mism++;
                if (if1.busy !== 1'b1 || if1.done !== 1'b0 || if1.err !== 1'b0) mism++;
                if (if1.sync === 1'b1) nsync++;
            end else if (k == FR1 * nfr) begin
                check({tag, "_end_busy"}, 32'(if1.busy), 32'd0);
                check({tag, "_end_done"}, 32'(if1.done), 32'd1);
                check({tag, "_end_cod"},  32'(if1.cod_o), 32'd0);
            end else begin
                check({tag, "_done_len"}, 32'(if1.done), 32'd0);
            end
            if (k == chg_k)       if1.A     = a_new;
            if (k == drop_k)      if1.hold  = 1'b0;
            if (k == pulse_k)     if1.start = 1'b1;
            if (k == pulse_k + 1) if1.start = 1'b0;
        end
        check({tag, "_wave"}, 32'(mism), 32'd0);
        check({tag, "_sync_cycles"}, 32'(nsync), 32'(256 * nfr));
    endtask

    initial begin
        int          mism;
        logic [31:0] sy2;
        logic [63:0] w;
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        if1.start = 1'b0; if1.hold = 1'b0; if1.A = '0; if1.D = '0;
        if2.start = 1'b0; if2.hold = 1'b0; if2.A = '0; if2.D = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cod",   32'(if1.cod_o), 32'd0);
        check("rst_busy",  32'(if1.busy),  32'd0);
        check("rst_sync",  32'(if1.sync),  32'd0);
        check("rst_done",  32'(if1.done),  32'd0);
        check("rst_err",   32'(if1.err),   32'd0);
        check("rst2_busy", 32'(if2.busy),  32'd0);
        reset = 1'b0;

        // trit0='1', trit1='0', D=10; start re-pulse and A change mid-frame must not disturb it
        run1("basic", 4'b0011, 2'b10, 4'b1111, 50, -1, 100, 1);
        repeat (4) @(negedge clk);
        check("idle_after_basic", 32'(if1.busy), 32'd0);

        // reserved trit at start
        @(negedge clk);
        if1.A = 4'b1000; if1.D = 2'b00; if1.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if1.start = 1'b0;
        check("err_pulse", 32'(if1.err),   32'd1);
        check("err_busy",  32'(if1.busy),  32'd0);
        check("err_cod",   32'(if1.cod_o), 32'd0);
        @(negedge clk);
        check("err_len",   32'(if1.err),   32'd0);
        check("err_busy2", 32'(if1.busy),  32'd0);

        // reserved trit appearing at re-latch under hold
        if1.hold = 1'b1;
        @(negedge clk);
        if1.A = 4'b0011; if1.start = 1'b1;
        @(posedge clk);
        mism = 0;
        for (int k = 0; k <= FR1; k++) begin
            @(negedge clk);
            if (k == 0) if1.start = 1'b0;
            if (k < FR1) begin
                if (if1.busy !== 1'b1 || if1.err !== 1'b0) mism++;
            end else begin
                check("relatch_err",  32'(if1.err),  32'd1);
                check("relatch_busy", 32'(if1.busy), 32'd0);
                check("relatch_done", 32'(if1.done), 32'd0);
            end
            if (k == 300) if1.A = 4'b0010;
        end
        if1.hold = 1'b0;
        check("relatch_frame_busy", 32'(mism), 32'd0);

        // synchronous reset at phase 7 of the first symbol
        @(negedge clk);
        if1.A = 4'b0011; if1.D = 2'b10; if1.start = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 14; k++) begin
            @(negedge clk);
            if (k == 0) if1.start = 1'b0;
        end
        check("pre_reset_cod", 32'(if1.cod_o), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_cod",  32'(if1.cod_o), 32'd0);
        check("midrst_busy", 32'(if1.busy),  32'd0);
        check("midrst_sync", 32'(if1.sync),  32'd0);
        reset = 1'b0;
        run1("restart", 4'b0011, 2'b10, 4'b0011, -1, -1, -1, 1);

        // hold keeps REPEAT=1 going; new A shows from frame 1; hold dropped in frame 2
        if1.hold = 1'b1;
        run1("hold", 4'b0011, 2'b01, 4'b0101, 300, 2 * FR1 + 100, -1, 3);

        // default geometry, all-F address, two frames back-to-back
        sy2 = mk_syms({16'd0, 16'h5555}, 8, 8'h0F, 4);
        mism = 0;
        w    = '0;
        @(negedge clk);
        if2.A = 16'h5555; if2.D = 4'hF; if2.start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 2 * FR2 + 2; k++) begin
            @(negedge clk);
            if (k == 0) if2.start = 1'b0;
            if (k < 64) w[k] = if2.cod_o;
            if (k < 2 * FR2) begin
                if (if2.cod_o !== exp_cod(k % FR2, 12, 2, sy2)) mism++;
                if (if2.sync !== exp_sync(k % FR2, 12, 2)) mism++;
                if (if2.busy !== 1'b1 || if2.done !== 1'b0) mism++;
            end else if (k == 2 * FR2) begin
                check("def_end_done", 32'(if2.done), 32'd1);
                check("def_end_busy", 32'(if2.busy), 32'd0);
            end else begin
                check("def_done_len", 32'(if2.done), 32'd0);
            end
        end
        check("def_wave",   32'(mism),      32'd0);
        check("f_high8",    32'(w[7:0]),    32'hFF);
        check("f_low24",    32'(w[31:8]),   32'd0);
        check("f_high24",   32'(w[55:32]),  32'hFF_FFFF);
        check("f_tail_low", 32'(w[63:56]),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
